sfr_bus_ctrl: RTL and testbench
===============================

SFR_BUS_CTRL -- requirements
Module: sfr_bus_ctrl

Interface
REQ-001: The block SHALL have parameter WIDTH, default 8, meaning the SFR data width.
REQ-002: The block SHALL have parameter NSFR, default 16, meaning the number of bit-addressable SFR slots (byte addresses 0x80, 0x88, ... 0xF8).
REQ-003: The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004: The block SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request from the core.
- op  in  2  access type: 00 byte read, 01 byte write, 10 bit read, 11 bit write.
- addr  in  8  byte address for byte ops; 8051 bit address for bit ops.
- wdata  in  WIDTH  byte write data.
- wbit  in  1  bit write data.
- busy  out  1  transaction in progress.
- ack  out  1  one-cycle completion pulse.
- err  out  1  qualifies ack; set when the address is unsupported.
- rdata  out  WIDTH  captured byte read data.
- rbit  out  1  captured bit read data.
- sfr_en  out  NSFR  per-slot write strobe.
- sfr_oe  out  NSFR  per-slot output enable.
- sfr_Bb  out  1  1 selects byte access, 0 selects bit access.
- sfr_position  out  WIDTH  one-hot bit position.
- sfr_din  out  WIDTH  shared write data.
- sfr_bin  out  1  shared write bit.
- sfr_dout  in  WIDTH  shared SFR byte read bus.
- sfr_bout  in  1  shared SFR bit read line.

Function
REQ-005: The block SHALL implement states IDLE, DRIVE and DONE.
REQ-006: In IDLE with req=1 at a rising edge, the block SHALL latch op, addr, wdata and wbit and decode them:
- Slot = addr[6:3].
- Position = 1<<addr[2:0] for bit ops; all zero for byte ops.
- sfr_Bb = ~op[1].
REQ-007: A request SHALL be valid when both hold:
- addr[7]=1;
- for byte ops, addr[2:0]=0.
REQ-008: A valid request SHALL go IDLE->DRIVE->DONE->IDLE; an invalid request SHALL go IDLE->DONE->IDLE.
REQ-009: In DRIVE, the block SHALL assert exactly one strobe, sfr_en[slot] for writes or sfr_oe[slot] for reads, for exactly one cycle, never both.
REQ-010: In DRIVE, the block SHALL hold sfr_din=wdata, sfr_bin=wbit, sfr_position and sfr_Bb from the latched request.
REQ-011: On reads, rdata (byte) or rbit (bit) SHALL be captured at the rising edge ending DRIVE, because the SFR registers its output on the falling edge inside DRIVE.
REQ-012: rdata and rbit SHALL hold their value until the next successful read of the same kind.
REQ-013: Writes SHALL NOT alter rdata or rbit.
REQ-014: Latency for a request accepted at edge N:
- Valid request: DRIVE occupies cycle N+1, ack=1 in cycle N+2.
- Invalid request: ack=1 and err=1 in cycle N+1, with no sfr_en or sfr_oe strobe.
REQ-015: busy SHALL be 1 in every non-IDLE cycle.
REQ-016: ack SHALL be high only in DONE.
REQ-017: err SHALL be valid only while ack=1 and SHALL be 0 otherwise.
REQ-018: req SHALL be sampled only in IDLE; req asserted in DRIVE or DONE SHALL be ignored and not queued; a request held through DONE SHALL be accepted on the first IDLE edge.
REQ-019: Outside DRIVE, the block SHALL drive sfr_en=0, sfr_oe=0, sfr_position=0, sfr_din=0, sfr_bin=0 and sfr_Bb=1.
REQ-020: Bit writes SHALL be single-cycle strobes; the read-modify-write is performed inside the SFR.

Reset
REQ-021: reset=0 SHALL immediately force:
- state IDLE;
- busy=0, ack=0, err=0;
- rdata=0, rbit=0;
- all sfr_* outputs to their REQ-019 idle values.
REQ-022: reset asserted mid-transaction SHALL abort the transaction without an ack; a write aborted in DRIVE is not guaranteed to have reached the SFR.
REQ-023: The first rising edge after reset release SHALL be able to accept a request.

Verification
REQ-024: Byte write op=01, addr=0x90, wdata=0xA5 accepted at edge N -> cycle N+1: sfr_en=16'h0004, sfr_oe=0, sfr_Bb=1, sfr_din=0xA5, sfr_position=0; cycle N+2: ack=1, err=0.
REQ-025: Bit write op=11, addr=0x93, wbit=1 -> cycle N+1: sfr_en=16'h0004, sfr_Bb=0, sfr_position=0x08, sfr_bin=1; cycle N+2: ack=1.
REQ-026: Bit read op=10, addr=0xE7, bench drives sfr_bout=1 after the DRIVE falling edge -> sfr_oe=16'h1000 and sfr_position=0x80 in N+1; rbit=1 with ack in N+2. Byte read op=00, addr=0xF8, sfr_dout=0x3C -> sfr_oe=16'h8000, rdata=0x3C.
REQ-027: Byte read at addr=0x81, and bit write at addr=0x40 -> no strobes; ack=1, err=1 in N+1; rdata and rbit unchanged.
REQ-028: req held high continuously -> accepts at N, N+3, N+6; at most one strobe per 3 cycles; no request accepted while busy=1.
REQ-029: reset=0 asserted during DRIVE -> strobes, busy and ack drop to 0 without waiting for a clock edge; no ack follows; after release, a byte write to 0x80 completes normally with sfr_en=16'h0001.

Source files
------------

// File: rtl/sfr_bus_ctrl.sv
// sfr_bus_ctrl: bridges single core requests onto a shared 8051-style SFR
// bus. A request is latched in IDLE and decoded to a slot strobe. Valid
// requests then go through one DRIVE cycle and one DONE (ack) cycle.
// Invalid addresses skip DRIVE and complete with err.
//
// Ports
//   clk, reset          clock, async active-low reset
//   req, op, addr       request, access type {bit, write}, byte/bit address
//   wdata, wbit         byte / bit write data
//   busy, ack, err      in-progress flag, completion pulse, error qualifier
//   rdata, rbit         last captured byte / bit read data
//   sfr_en, sfr_oe      per-slot write strobe / output enable (DRIVE only)
//   sfr_Bb              1 = byte access, 0 = bit access
//   sfr_position        one-hot bit position for bit ops
//   sfr_din, sfr_bin    shared write data / bit
//   sfr_dout, sfr_bout  shared read bus / bit line
module sfr_bus_ctrl #(
   parameter int WIDTH = 8,
   parameter int NSFR  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [1:0]       op,
   input  logic [7:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             wbit,
   output logic             busy,
   output logic             ack,
   output logic             err,
   output logic [WIDTH-1:0] rdata,
   output logic             rbit,
   output logic [NSFR-1:0]  sfr_en,
   output logic [NSFR-1:0]  sfr_oe,
   output logic             sfr_Bb,
   output logic [WIDTH-1:0] sfr_position,
   output logic [WIDTH-1:0] sfr_din,
   output logic             sfr_bin,
   input  logic [WIDTH-1:0] sfr_dout,
   input  logic             sfr_bout
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

   localparam logic [NSFR-1:0]  SLOT_ONE = NSFR'(1);
   localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1);

   state_e           state_q, state_d;
   logic [1:0]       op_q;
   logic [3:0]       slot_q;
   logic [2:0]       bsel_q;
   logic [WIDTH-1:0] wdata_q;
   logic             wbit_q;
   logic             err_q;
   logic [WIDTH-1:0] rdata_q;
   logic             rbit_q;

   logic accept, valid;

   assign accept = (state_q == IDLE) && req;
   // Byte ops must hit an 8-aligned address; slots beyond NSFR are unmapped.
   assign valid  = addr[7] && (op[1] || (addr[2:0] == 3'd0)) &&
                   (int'(addr[6:3]) < NSFR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = valid ? DRIVE : DONE;
         DRIVE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         slot_q  <= '0;
         bsel_q  <= '0;
         wdata_q <= '0;
         wbit_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         rbit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op;
            slot_q  <= addr[6:3];
            bsel_q  <= addr[2:0];
            wdata_q <= wdata;
            wbit_q  <= wbit;
            err_q   <= !valid;
         end
         // The SFR presents read data from the falling edge inside DRIVE,
         // so the edge that ends DRIVE captures it.
         if (state_q == DRIVE && !op_q[0]) begin
            if (op_q[1]) rbit_q  <= sfr_bout;
            else         rdata_q <= sfr_dout;
         end
      end
   end

   always_comb begin
      sfr_en       = '0;
      sfr_oe       = '0;
      sfr_Bb       = 1'b1;
      sfr_position = '0;
      sfr_din      = '0;
      sfr_bin      = 1'b0;
      if (state_q == DRIVE) begin
         if (op_q[0]) sfr_en = SLOT_ONE << slot_q;
         else         sfr_oe = SLOT_ONE << slot_q;
         sfr_Bb       = !op_q[1];
         sfr_position = op_q[1] ? (POS_ONE << bsel_q) : '0;
         sfr_din      = wdata_q;
         sfr_bin      = wbit_q;
      end
   end

   assign busy  = (state_q != IDLE);
   assign ack   = (state_q == DONE);
   assign err   = (state_q == DONE) && err_q;
   assign rdata = rdata_q;
   assign rbit  = rbit_q;

endmodule

// File: tb/tb_sfr_bus_ctrl.sv
module tb_sfr_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic        wbit = 1'b0;
  logic        busy, ack, err, rbit, sfr_Bb, sfr_bin;
  logic [7:0]  rdata, sfr_position, sfr_din;
  logic [15:0] sfr_en, sfr_oe;
  logic [7:0]  sfr_dout = 8'h00;
  logic        sfr_bout = 1'b0;

  int checks = 0;
  int errors = 0;

  sfr_bus_ctrl #(.WIDTH(8), .NSFR(16)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
    .wdata(wdata), .wbit(wbit), .busy(busy), .ack(ack), .err(err),
    .rdata(rdata), .rbit(rbit), .sfr_en(sfr_en), .sfr_oe(sfr_oe),
    .sfr_Bb(sfr_Bb), .sfr_position(sfr_position), .sfr_din(sfr_din),
    .sfr_bin(sfr_bin), .sfr_dout(sfr_dout), .sfr_bout(sfr_bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] wd, input logic wb);
    op = o; addr = a; wdata = wd; wbit = wb; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " en"},  sfr_en === 16'h0000, sfr_en, 16'h0000);
    chk({tag, " oe"},  sfr_oe === 16'h0000, sfr_oe, 16'h0000);
    chk({tag, " Bb"},  sfr_Bb === 1'b1, sfr_Bb, 1'b1);
    chk({tag, " pos"}, sfr_position === 8'h00, sfr_position, 8'h00);
    chk({tag, " din"}, sfr_din === 8'h00, sfr_din, 8'h00);
    chk({tag, " bin"}, sfr_bin === 1'b0, sfr_bin, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst busy", busy === 1'b0, busy, 1'b0);
    chk("rst ack", ack === 1'b0, ack, 1'b0);
    chk("rst err", err === 1'b0, err, 1'b0);
    chk("rst rdata", rdata === 8'h00, rdata, 8'h00);
    chk("rst rbit", rbit === 1'b0, rbit, 1'b0);
    chk_idle_bus("rst");
    reset = 1'b1;

    issue(2'b01, 8'h90, 8'hA5, 1'b0);
    chk("bw busy", busy === 1'b1, busy, 1'b1);
    chk("bw en", sfr_en === 16'h0004, sfr_en, 16'h0004);
    chk("bw oe", sfr_oe === 16'h0000, sfr_oe, 16'h0000);
    chk("bw Bb", sfr_Bb === 1'b1, sfr_Bb, 1'b1);
    chk("bw din", sfr_din === 8'hA5, sfr_din, 8'hA5);
    chk("bw pos", sfr_position === 8'h00, sfr_position, 8'h00);
    chk("bw ack early", ack === 1'b0, ack, 1'b0);
    tick();
    chk("bw ack", ack === 1'b1, ack, 1'b1);
    chk("bw err", err === 1'b0, err, 1'b0);
    chk("bw busy done", busy === 1'b1, busy, 1'b1);
    chk_idle_bus("bw done");
    tick();
    chk("bw idle busy", busy === 1'b0, busy, 1'b0);
    chk("bw idle ack", ack === 1'b0, ack, 1'b0);

    issue(2'b11, 8'h93, 8'h00, 1'b1);
    chk("btw en", sfr_en === 16'h0004, sfr_en, 16'h0004);
    chk("btw oe", sfr_oe === 16'h0000, sfr_oe, 16'h0000);
    chk("btw Bb", sfr_Bb === 1'b0, sfr_Bb, 1'b0);
    chk("btw pos", sfr_position === 8'h08, sfr_position, 8'h08);
    chk("btw bin", sfr_bin === 1'b1, sfr_bin, 1'b1);
    tick();
    chk("btw ack", ack === 1'b1, ack, 1'b1);
    chk("btw err", err === 1'b0, err, 1'b0);
    tick();

    issue(2'b10, 8'hE7, 8'h00, 1'b0);
    chk("br oe", sfr_oe === 16'h1000, sfr_oe, 16'h1000);
    chk("br en", sfr_en === 16'h0000, sfr_en, 16'h0000);
    chk("br pos", sfr_position === 8'h80, sfr_position, 8'h80);
    chk("br Bb", sfr_Bb === 1'b0, sfr_Bb, 1'b0);
    @(negedge clk); #1 sfr_bout = 1'b1;
    tick();
    chk("br ack", ack === 1'b1, ack, 1'b1);
    chk("br rbit", rbit === 1'b1, rbit, 1'b1);
    chk("br rdata kept", rdata === 8'h00, rdata, 8'h00);
    sfr_bout = 1'b0;
    tick();

    sfr_dout = 8'h3C;
    issue(2'b00, 8'hF8, 8'h00, 1'b0);
    chk("rd oe", sfr_oe === 16'h8000, sfr_oe, 16'h8000);
    chk("rd Bb", sfr_Bb === 1'b1, sfr_Bb, 1'b1);
    chk("rd pos", sfr_position === 8'h00, sfr_position, 8'h00);
    tick();
    chk("rd ack", ack === 1'b1, ack, 1'b1);
    chk("rd rdata", rdata === 8'h3C, rdata, 8'h3C);
    chk("rd rbit kept", rbit === 1'b1, rbit, 1'b1);
    tick();

    sfr_dout = 8'hFF; sfr_bout = 1'b0;
    issue(2'b00, 8'h81, 8'h00, 1'b0);
    chk("inv1 ack", ack === 1'b1, ack, 1'b1);
    chk("inv1 err", err === 1'b1, err, 1'b1);
    chk("inv1 busy", busy === 1'b1, busy, 1'b1);
    chk_idle_bus("inv1");
    tick();
    chk("inv1 ack gone", ack === 1'b0, ack, 1'b0);
    chk("inv1 err gone", err === 1'b0, err, 1'b0);
    chk("inv1 busy gone", busy === 1'b0, busy, 1'b0);
    issue(2'b11, 8'h40, 8'h00, 1'b1);
    chk("inv2 ack", ack === 1'b1, ack, 1'b1);
    chk("inv2 err", err === 1'b1, err, 1'b1);
    chk_idle_bus("inv2");
    tick();
    chk("inv rdata kept", rdata === 8'h3C, rdata, 8'h3C);
    chk("inv rbit kept", rbit === 1'b1, rbit, 1'b1);

    sfr_dout = 8'h55;
    op = 2'b01; addr = 8'h88; wdata = 8'h11; req = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("held en %0d", i),
          sfr_en === ((i % 3 == 0) ? 16'h0002 : 16'h0000),
          sfr_en, (i % 3 == 0) ? 16'h0002 : 16'h0000);
      chk($sformatf("held busy %0d", i),
          busy === (i % 3 != 2), busy, (i % 3 != 2));
      chk($sformatf("held ack %0d", i),
          ack === (i % 3 == 1), ack, (i % 3 == 1));
      if (i != 8) tick();
    end
    req = 1'b0;
    tick();
    chk("held idle busy", busy === 1'b0, busy, 1'b0);
    chk("held rdata kept", rdata === 8'h3C, rdata, 8'h3C);

    issue(2'b01, 8'hA0, 8'h77, 1'b0);
    chk("abort en pre", sfr_en === 16'h0010, sfr_en, 16'h0010);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", busy === 1'b0, busy, 1'b0);
    chk("abort ack", ack === 1'b0, ack, 1'b0);
    chk("abort rdata", rdata === 8'h00, rdata, 8'h00);
    chk("abort rbit", rbit === 1'b0, rbit, 1'b0);
    chk_idle_bus("abort");
    tick();
    chk("abort no ack", ack === 1'b0, ack, 1'b0);
    reset = 1'b1;
    issue(2'b01, 8'h80, 8'h5A, 1'b0);
    chk("post en", sfr_en === 16'h0001, sfr_en, 16'h0001);
    chk("post din", sfr_din === 8'h5A, sfr_din, 8'h5A);
    tick();
    chk("post ack", ack === 1'b1, ack, 1'b1);
    chk("post err", err === 1'b0, err, 1'b0);
    tick();
    chk("post idle", busy === 1'b0, busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
